// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD write path: scheduler states,
// register-select encodings and the fixed HD44780-style instruction bytes.
package lcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR1,
        LINE1,
        ADDR2,
        LINE2
    } state_e;

    localparam logic RS_CMD  = 1'b0;
    localparam logic RS_DATA = 1'b1;

    localparam logic [7:0] CLEAR      = 8'h01;
    localparam logic [7:0] LINE1_ADDR = 8'h80;
    localparam logic [7:0] LINE2_ADDR = 8'hC0;

    // Character states stream buffer bytes with RS high; all others send instructions.
    function automatic logic is_data_state(input state_e s);
        return (s == LINE1) || (s == LINE2);
    endfunction

endpackage

// File: rtl/lcd_wr_handshake.sv
// Owns the wr_enable strobe towards the write-cycle engine: inserts the gap
// cycle before each item and only honours wr_finish while a write is active.
module lcd_wr_handshake
    import lcd_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic item_req_i,
    input  logic wr_finish_i,
    output logic wr_enable_o,
    output logic item_start_o,
    output logic item_done_o
);

    logic wr_en_q;
    logic wr_en_d;

    // A low wr_enable cycle always precedes a rise, which gives the gap between items.
    always_comb begin
        wr_en_d      = wr_en_q;
        item_start_o = 1'b0;
        item_done_o  = 1'b0;
        if (wr_en_q) begin
            if (wr_finish_i) begin
                wr_en_d     = 1'b0;
                item_done_o = 1'b1;
            end
        end else if (item_req_i) begin
            wr_en_d      = 1'b1;
            item_start_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_en_q <= 1'b0;
        end else begin
            wr_en_q <= wr_en_d;
        end
    end

    assign wr_enable_o = wr_en_q;

endmodule

// File: rtl/lcd_write_scheduler.sv
// Arbitrates one-shot LCD instructions against full two-line screen refreshes
// and sequences every resulting byte through the shared write-cycle engine.
module lcd_write_scheduler #(
    parameter int unsigned LINE_LEN   = 16,
    parameter logic [7:0]  LINE1_ADDR = lcd_pkg::LINE1_ADDR,
    parameter logic [7:0]  LINE2_ADDR = lcd_pkg::LINE2_ADDR
) (
    input  logic       clk_1ms,
    input  logic       reset,
    input  logic       refresh_req,
    input  logic       cmd_req,
    input  logic [7:0] cmd_code,
    output logic       cmd_ack,
    output logic [4:0] char_addr,
    input  logic [7:0] char_data,
    output logic       wr_enable,
    input  logic       wr_finish,
    output logic       reg_sel,
    output logic [7:0] db_out,
    output logic       busy,
    output logic       refresh_done
);

    import lcd_pkg::*;

    localparam logic [3:0] LAST_IDX   = 4'(LINE_LEN - 1);
    localparam logic [4:0] LINE2_BASE = 5'(LINE_LEN);

    state_e     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic       ref_pend_q, ref_pend_d;
    logic       last_ref_q, last_ref_d;
    logic [7:0] cmd_byte_q, cmd_byte_d;
    logic [7:0] db_q, db_d;
    logic       rs_q, rs_d;

    logic       item_req;
    logic       item_start;
    logic       item_done;
    logic       ref_want;
    logic       grant_cmd;
    logic       grant_ref;
    logic       item_rs;
    logic [7:0] item_byte;

    lcd_wr_handshake u_handshake (
        .clk_i        (clk_1ms),
        .rst_i        (reset),
        .item_req_i   (item_req),
        .wr_finish_i  (wr_finish),
        .wr_enable_o  (wr_enable),
        .item_start_o (item_start),
        .item_done_o  (item_done)
    );

    assign item_req = (state_q != IDLE);

    // A refresh request arriving in the very cycle IDLE evaluates still competes for the grant.
    // On a tie, the requester that did not win last time gets the engine.
    always_comb begin
        ref_want  = ref_pend_q | refresh_req;
        grant_cmd = (state_q == IDLE) && cmd_req && (!ref_want || last_ref_q);
        grant_ref = (state_q == IDLE) && ref_want && !grant_cmd;
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        ref_pend_d   = ref_pend_q | refresh_req;
        last_ref_d   = last_ref_q;
        cmd_byte_d   = cmd_byte_q;
        cmd_ack      = 1'b0;
        refresh_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant_cmd) begin
                    state_d    = CMD;
                    cmd_byte_d = cmd_code;
                    last_ref_d = 1'b0;
                end else if (grant_ref) begin
                    state_d    = ADDR1;
                    idx_d      = '0;
                    ref_pend_d = 1'b0;
                    last_ref_d = 1'b1;
                end
            end
            CMD: begin
                if (item_done) begin
                    state_d = IDLE;
                    cmd_ack = 1'b1;
                end
            end
            ADDR1: begin
                if (item_done) begin
                    state_d = LINE1;
                end
            end
            LINE1: begin
                if (item_done) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ADDR2;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            ADDR2: begin
                if (item_done) begin
                    state_d = LINE2;
                end
            end
            LINE2: begin
                if (item_done) begin
                    if (idx_q == LAST_IDX) begin
                        state_d      = IDLE;
                        idx_d        = '0;
                        refresh_done = 1'b1;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // The byte for the upcoming item is selected during its gap cycle and frozen when wr_enable rises.
    always_comb begin
        item_rs   = RS_CMD;
        item_byte = 8'h00;
        if (is_data_state(state_q)) begin
            item_rs   = RS_DATA;
            item_byte = char_data;
        end else begin
            unique case (state_q)
                CMD:     item_byte = cmd_byte_q;
                ADDR1:   item_byte = LINE1_ADDR;
                ADDR2:   item_byte = LINE2_ADDR;
                default: item_byte = 8'h00;
            endcase
        end
        db_d = item_start ? item_byte : db_q;
        rs_d = item_start ? item_rs   : rs_q;
    end

    assign char_addr = (state_q == LINE2) ? (LINE2_BASE + {1'b0, idx_q}) : {1'b0, idx_q};
    assign busy      = (state_q != IDLE);
    assign reg_sel   = rs_q;
    assign db_out    = db_q;

    always_ff @(posedge clk_1ms or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            ref_pend_q <= 1'b0;
            last_ref_q <= 1'b1;
            cmd_byte_q <= 8'h00;
            db_q       <= 8'h00;
            rs_q       <= RS_CMD;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ref_pend_q <= ref_pend_d;
            last_ref_q <= last_ref_d;
            cmd_byte_q <= cmd_byte_d;
            db_q       <= db_d;
            rs_q       <= rs_d;
        end
    end

endmodule

// File: tb/tb_lcd_write_scheduler.sv
// Directed bench for lcd_write_scheduler with an L-cycle engine model and a
// write scoreboard fed in grant order by a small last-grant model.
module tb_lcd_write_scheduler;

    localparam int L        = 3;
    localparam int LINE_LEN = 16;
    localparam int CMD_LAT  = L + 1;
    localparam int REF_LAT  = (2 * LINE_LEN + 2) * (L + 2) - 1;
    localparam int BUDGET   = 1000;

    logic       clk_1ms = 1'b0;
    logic       reset;
    logic       refresh_req;
    logic       cmd_req;
    logic [7:0] cmd_code;
    logic       cmd_ack;
    logic [4:0] char_addr;
    logic [7:0] char_data;
    logic       wr_enable;
    logic       wr_finish;
    logic       reg_sel;
    logic [7:0] db_out;
    logic       busy;
    logic       refresh_done;

    logic [7:0] buffer [2*LINE_LEN];
    logic       engFin;
    int         engCnt;
    logic       spurOn;

    int         cyc = 0;
    int         grantCyc = 0;
    int         testsRun = 0;
    int         failCount = 0;
    int         ackCount = 0;
    int         doneCount = 0;
    int         expAck = 0;
    int         expDone = 0;
    logic       lastRef = 1'b1;
    logic [8:0] expQ [$];

    lcd_write_scheduler #(.LINE_LEN(LINE_LEN)) dut (
        .clk_1ms      (clk_1ms),
        .reset        (reset),
        .refresh_req  (refresh_req),
        .cmd_req      (cmd_req),
        .cmd_code     (cmd_code),
        .cmd_ack      (cmd_ack),
        .char_addr    (char_addr),
        .char_data    (char_data),
        .wr_enable    (wr_enable),
        .wr_finish    (wr_finish),
        .reg_sel      (reg_sel),
        .db_out       (db_out),
        .busy         (busy),
        .refresh_done (refresh_done)
    );

    always #5 clk_1ms = ~clk_1ms;

    always @(posedge clk_1ms) cyc <= cyc + 1;

    assign char_data = buffer[char_addr];

    // Engine: finish pulse arrives L cycles after wr_enable rises; spurOn adds finish pulses outside writes.
    always @(posedge clk_1ms or posedge reset) begin
        if (reset) begin
            engFin <= 1'b0;
            engCnt <= 0;
        end else begin
            engFin <= 1'b0;
            if (wr_enable && !engFin) begin
                if (engCnt == L - 1) begin
                    engFin <= 1'b1;
                    engCnt <= 0;
                end else begin
                    engCnt <= engCnt + 1;
                end
            end
        end
    end

    assign wr_finish = engFin | (spurOn & ~wr_enable);

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic cmdReq, input logic [7:0] code, input logic refReq);
        cmd_req     = cmdReq;
        cmd_code    = code;
        refresh_req = refReq;
    endtask

    task automatic tick();
        @(negedge clk_1ms);
        #1;
    endtask

    function automatic logic [31:0] outVec();
        return 32'({wr_enable, reg_sel, db_out, char_addr, busy, cmd_ack, refresh_done});
    endfunction

    task automatic pushCmd(input logic [7:0] code);
        expQ.push_back({1'b0, code});
        lastRef = 1'b0;
    endtask

    task automatic pushRefresh();
        expQ.push_back({1'b0, 8'h80});
        for (int i = 0; i < LINE_LEN; i++) expQ.push_back({1'b1, 8'(8'h41 + i)});
        expQ.push_back({1'b0, 8'hC0});
        for (int i = 0; i < LINE_LEN; i++) expQ.push_back({1'b1, 8'(8'h41 + LINE_LEN + i)});
        lastRef = 1'b1;
    endtask

    task automatic contest(input logic [7:0] code);
        if (lastRef) begin
            pushCmd(code);
            pushRefresh();
        end else begin
            pushRefresh();
            pushCmd(code);
        end
        expAck++;
        expDone++;
        applyStimulus(1'b1, code, 1'b1);
        tick();
        applyStimulus(1'b1, code, 1'b0);
    endtask

    task automatic pulseRefresh();
        applyStimulus(cmd_req, cmd_code, 1'b1);
        tick();
        applyStimulus(cmd_req, cmd_code, 1'b0);
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        while (!(ackCount >= expAck && doneCount >= expDone && !busy) && n < BUDGET) begin
            tick();
            if (cmd_ack) cmd_req = 1'b0;
            n++;
        end
        checkOutput(tag, 32'(n < BUDGET), 32'd1);
    endtask

    task automatic idleCheck(input string tag, input int cycles);
        logic sawBusy = 1'b0;
        repeat (cycles) begin
            tick();
            sawBusy |= busy;
        end
        checkOutput(tag, 32'(sawBusy), 32'd0);
    endtask

    // Monitor: scoreboard pops on each wr_enable rise, plus stability, latency and pulse-width checks.
    initial begin
        logic [8:0] expW;
        logic [8:0] heldW = '0;
        logic       prevWe = 1'b0;
        logic       prevBusy = 1'b0;
        logic       prevAck = 1'b0;
        logic       prevDone = 1'b0;
        forever begin
            @(negedge clk_1ms);
            if (wr_enable && !prevWe) begin
                checkOutput("write_expected", 32'(expQ.size() > 0), 32'd1);
                if (expQ.size() > 0) begin
                    expW = expQ.pop_front();
                    checkOutput("write_rs_db", 32'({reg_sel, db_out}), 32'(expW));
                end
                heldW = {reg_sel, db_out};
            end else if (wr_enable) begin
                checkOutput("write_stable", 32'({reg_sel, db_out}), 32'(heldW));
            end
            if (busy && !prevBusy) grantCyc = cyc;
            if (cmd_ack) begin
                ackCount++;
                checkOutput("cmd_ack_latency", 32'(cyc - grantCyc), 32'(CMD_LAT));
                checkOutput("cmd_ack_width", 32'(prevAck), 32'd0);
                checkOutput("cmd_ack_in_write", 32'({wr_enable, busy}), 32'd3);
            end
            if (refresh_done) begin
                doneCount++;
                checkOutput("refresh_latency", 32'(cyc - grantCyc), 32'(REF_LAT));
                checkOutput("refresh_done_width", 32'(prevDone), 32'd0);
                checkOutput("refresh_done_in_write", 32'({wr_enable, busy}), 32'd3);
            end
            prevWe   = wr_enable;
            prevBusy = busy;
            prevAck  = cmd_ack;
            prevDone = refresh_done;
        end
    end

    initial begin
        int n;
        reset  = 1'b1;
        spurOn = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 2 * LINE_LEN; i++) buffer[i] = 8'(8'h41 + i);
        repeat (3) tick();
        checkOutput("reset_outputs", outVec(), 32'd0);
        reset = 1'b0;
        tick();

        contest(8'h01);
        waitIdle("contest1_timeout");
        contest(8'h0C);
        waitIdle("contest2_timeout");

        pushCmd(8'h01);
        expAck++;
        applyStimulus(1'b1, 8'h01, 1'b0);
        waitIdle("cmd_timeout");
        idleCheck("cmd_no_rerun", 5);

        contest(8'h10);
        waitIdle("contest3_timeout");

        spurOn = 1'b1;
        repeat (5) tick();
        pushRefresh();
        expDone++;
        pulseRefresh();
        waitIdle("spurious_refresh_timeout");
        idleCheck("spurious_idle", 5);
        spurOn = 1'b0;

        pushRefresh();
        pushRefresh();
        expDone += 2;
        pulseRefresh();
        repeat (20) tick();
        pulseRefresh();
        repeat (30) tick();
        pulseRefresh();
        repeat (30) tick();
        pulseRefresh();
        waitIdle("coalesce_timeout");
        idleCheck("coalesce_single_extra", 20);

        pushRefresh();
        pulseRefresh();
        repeat (5) tick();
        pulseRefresh();
        n = 0;
        while (!(wr_enable && reg_sel && char_addr >= 5'd3 && char_addr < 5'd16) && n < 300) begin
            tick();
            n++;
        end
        checkOutput("reach_line1_timeout", 32'(n < 300), 32'd1);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_reset_outputs", outVec(), 32'd0);
        expQ.delete();
        lastRef = 1'b1;
        tick();
        reset = 1'b0;
        idleCheck("reset_drops_pending", 20);

        contest(8'h02);
        waitIdle("contest_after_reset_timeout");
        idleCheck("final_idle", 5);

        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        checkOutput("ack_count", 32'(ackCount), 32'(expAck));
        checkOutput("done_count", 32'(doneCount), 32'(expDone));

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
